// File: rtl/flit_queue_checked.sv
// First-word-fall-through flit FIFO with per-flit checksum validation,
// drop-or-tag handling of corrupt flits and saturating error statistics.

package types;
  typedef enum logic [1:0] {NOPE = 2'd0, HEAD = 2'd1, BODY = 2'd2, TAIL = 2'd3} flit_kind_t;

  typedef struct packed {
    flit_kind_t  kind;
    logic [5:0]  packet_id;
    logic [15:0] payload;
    logic [7:0]  checksum;
  } flit_t;
endpackage

// Checksum covers the flit kind and payload; the routing id is protected elsewhere.
module calculate_checksum_comb (
  input  types::flit_t flit,
  output logic         is_valid
);
  logic [7:0] expected_sum;

  always_comb begin
    expected_sum = flit.payload[15:8] ^ flit.payload[7:0] ^ {6'd0, flit.kind};
    is_valid     = (expected_sum == flit.checksum);
  end
endmodule

module flit_queue_checked #(
  parameter int DEPTH       = 8,
  parameter int CHECK_MODE  = 1,
  parameter int AFULL_LEVEL = DEPTH - 2,
  parameter int ERRCNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  types::flit_t               flit_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output types::flit_t               flit_out,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       err_pulse,
  output logic [ERRCNT_W-1:0]        err_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  types::flit_t     mem     [DEPTH];
  logic             tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             chk_valid;
  logic             push;
  logic             pop;
  logic             bad;
  logic             write_en;
  logic             err_event;

  calculate_checksum_comb u_chk (
    .flit     (flit_in),
    .is_valid (chk_valid)
  );

  // Handshake flags depend only on registered occupancy, never on the opposite side.
  always_comb begin
    in_ready    = (count != CNT_W'(DEPTH));
    out_valid   = (count != '0);
    almost_full = (count >= CNT_W'(AFULL_LEVEL));
    push        = in_valid && in_ready;
    pop         = out_valid && out_ready;
    bad         = (CHECK_MODE != 0) && !chk_valid;
    write_en    = push && !flush && !((CHECK_MODE == 1) && bad);
    err_event   = push && !flush && bad;
    flit_out    = mem[rd_ptr];
    out_err     = (CHECK_MODE == 2) && out_valid && tag_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr]     <= flit_in;
      tag_mem[wr_ptr] <= bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
      case ({write_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The counter follows the registered strobe, so it is untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= err_event;
      if (err_pulse && (err_count != '1)) err_count <= err_count + ERRCNT_W'(1);
    end
  end
endmodule

// File: tb/tb_flit_queue_checked.sv
// Scoreboard bench: a drop-mode queue and a tag-mode queue share one stimulus stream.
module tb_flit_queue_checked;
  import types::*;

  localparam int DEPTH = 8;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  flush = 1'b0;
  logic  in_valid = 1'b0;
  logic  out_ready = 1'b0;
  flit_t flit_in = '0;

  logic       in_ready_1, out_valid_1, out_err_1, almost_full_1, err_pulse_1;
  logic       in_ready_2, out_valid_2, out_err_2, almost_full_2, err_pulse_2;
  flit_t      flit_out_1, flit_out_2;
  logic [3:0] count_1, count_2;
  logic [7:0] err_count_1, err_count_2;

  int tests = 0;
  int failures = 0;

  typedef struct {
    flit_t flit;
    logic  tag;
  } entry_t;

  entry_t sb1[$];
  entry_t sb2[$];
  logic   exp_pulse_1 = 1'b0;
  logic   exp_pulse_2 = 1'b0;
  int     exp_cnt_1 = 0;
  int     exp_cnt_2 = 0;

  always #5 clk = ~clk;

  flit_queue_checked #(.DEPTH(DEPTH), .CHECK_MODE(1)) u_drop (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_1), .flit_in(flit_in),
    .out_valid(out_valid_1), .out_ready(out_ready), .flit_out(flit_out_1),
    .out_err(out_err_1), .count(count_1), .almost_full(almost_full_1),
    .err_pulse(err_pulse_1), .err_count(err_count_1)
  );

  flit_queue_checked #(.DEPTH(DEPTH), .CHECK_MODE(2)) u_tag (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_2), .flit_in(flit_in),
    .out_valid(out_valid_2), .out_ready(out_ready), .flit_out(flit_out_2),
    .out_err(out_err_2), .count(count_2), .almost_full(almost_full_2),
    .err_pulse(err_pulse_2), .err_count(err_count_2)
  );

  function automatic logic [7:0] sum_of(flit_t f);
    return f.payload[15:8] ^ f.payload[7:0] ^ {6'd0, f.kind};
  endfunction

  function automatic flit_t make_flit(flit_kind_t kind, logic [5:0] id, logic [15:0] payload, bit good);
    flit_t f;
    f.kind      = kind;
    f.packet_id = id;
    f.payload   = payload;
    f.checksum  = 8'h00;
    f.checksum  = sum_of(f) ^ (good ? 8'h00 : 8'h01);
    return f;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(logic v, flit_t f, logic r, logic fl);
    in_valid  = v;
    flit_in   = f;
    out_ready = r;
    flush     = fl;
  endtask

  task automatic checkState();
    checkOutput("count_1",       32'(count_1),       32'(sb1.size()));
    checkOutput("in_ready_1",    32'(in_ready_1),    32'(sb1.size() != DEPTH));
    checkOutput("out_valid_1",   32'(out_valid_1),   32'(sb1.size() != 0));
    checkOutput("almost_full_1", 32'(almost_full_1), 32'(sb1.size() >= DEPTH - 2));
    checkOutput("err_pulse_1",   32'(err_pulse_1),   32'(exp_pulse_1));
    checkOutput("err_count_1",   32'(err_count_1),   32'(exp_cnt_1));
    checkOutput("count_2",       32'(count_2),       32'(sb2.size()));
    checkOutput("in_ready_2",    32'(in_ready_2),    32'(sb2.size() != DEPTH));
    checkOutput("out_valid_2",   32'(out_valid_2),   32'(sb2.size() != 0));
    checkOutput("err_pulse_2",   32'(err_pulse_2),   32'(exp_pulse_2));
    checkOutput("err_count_2",   32'(err_count_2),   32'(exp_cnt_2));
  endtask

  // One clock: handshakes are decided from the model at the falling edge.
  task automatic tick();
    bit     bad, push1, pop1, push2, pop2;
    entry_t e;
    @(negedge clk);
    bad   = (sum_of(flit_in) != flit_in.checksum);
    push1 = in_valid && (sb1.size() != DEPTH);
    pop1  = out_ready && (sb1.size() != 0);
    push2 = in_valid && (sb2.size() != DEPTH);
    pop2  = out_ready && (sb2.size() != 0);
    if (sb1.size() != 0) begin
      checkOutput("head_flit_1", flit_out_1, sb1[0].flit);
      checkOutput("head_err_1", 32'(out_err_1), 32'(0));
    end
    if (sb2.size() != 0) begin
      checkOutput("head_flit_2", flit_out_2, sb2[0].flit);
      checkOutput("head_err_2", 32'(out_err_2), 32'(sb2[0].tag));
    end
    if (exp_pulse_1 && exp_cnt_1 != 255) exp_cnt_1++;
    if (exp_pulse_2 && exp_cnt_2 != 255) exp_cnt_2++;
    if (flush) begin
      sb1.delete();
      sb2.delete();
      exp_pulse_1 = 1'b0;
      exp_pulse_2 = 1'b0;
    end else begin
      e.flit = flit_in;
      if (pop1) sb1.delete(0);
      if (push1 && !bad) begin
        e.tag = 1'b0;
        sb1.push_back(e);
      end
      exp_pulse_1 = push1 && bad;
      if (pop2) sb2.delete(0);
      if (push2) begin
        e.tag = bad;
        sb2.push_back(e);
      end
      exp_pulse_2 = push2 && bad;
    end
    @(posedge clk);
    #1;
    checkState();
  endtask

  // Asserts reset away from any edge so its effect is visible before the next clock.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    sb1.delete();
    sb2.delete();
    exp_pulse_1 = 1'b0;
    exp_pulse_2 = 1'b0;
    exp_cnt_1   = 0;
    exp_cnt_2   = 0;
    checkOutput("rst_out_valid_1", 32'(out_valid_1), 32'(0));
    checkOutput("rst_count_1",     32'(count_1),     32'(0));
    checkOutput("rst_err_count_1", 32'(err_count_1), 32'(0));
    checkOutput("rst_err_pulse_1", 32'(err_pulse_1), 32'(0));
    checkOutput("rst_afull_1",     32'(almost_full_1), 32'(0));
    checkOutput("rst_out_valid_2", 32'(out_valid_2), 32'(0));
    checkOutput("rst_out_err_2",   32'(out_err_2),   32'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkState();
  endtask

  initial begin
    // Fill with eight good flits, then drain in order.
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, make_flit(NOPE, 6'(i), 16'h0000, 1'b1), 1'b0, 1'b0);
      tick();
    end
    checkOutput("fill_count_1", 32'(count_1), 32'(8));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    repeat (DEPTH + 1) tick();

    // Corrupt flit between two good ones: dropped by one queue, tagged by the other.
    doReset();
    applyStimulus(1'b1, make_flit(HEAD, 6'd1, 16'h1234, 1'b1), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, make_flit(NOPE, 6'd0, 16'h0000, 1'b0), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, make_flit(TAIL, 6'd2, 16'hBEEF, 1'b1), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("drop_count_1", 32'(count_1), 32'(2));
    checkOutput("tag_count_2", 32'(count_2), 32'(3));
    checkOutput("drop_err_count_1", 32'(err_count_1), 32'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    repeat (4) tick();

    // Continuous streaming keeps occupancy at one.
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, make_flit(BODY, 6'(i + 10), 16'(i * 37), 1'b1), 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    repeat (2) tick();

    // Full queue with simultaneous pop: push is refused.
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, make_flit(BODY, 6'(i + 20), 16'(i * 91), 1'b1), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, make_flit(BODY, 6'd40, 16'h5A5A, 1'b1), 1'b1, 1'b0);
    tick();
    checkOutput("full_pop_count_1", 32'(count_1), 32'(7));
    checkOutput("full_pop_in_ready_1", 32'(in_ready_1), 32'(1));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();

    // Flush at count five with a simultaneous (bad) push.
    doReset();
    applyStimulus(1'b1, make_flit(NOPE, 6'd0, 16'h0000, 1'b0), 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, make_flit(HEAD, 6'(i), 16'(i * 5 + 1), 1'b1), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, make_flit(NOPE, 6'd0, 16'h0000, 1'b0), 1'b0, 1'b1);
    tick();
    checkOutput("flush_count_1", 32'(count_1), 32'(0));
    checkOutput("flush_out_valid_1", 32'(out_valid_1), 32'(0));
    checkOutput("flush_err_count_1", 32'(err_count_1), 32'(1));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    repeat (2) tick();

    // Reset in the middle of a drain.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, make_flit(BODY, 6'(i + 50), 16'(i * 3), 1'b1), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    repeat (2) tick();
    doReset();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    repeat (2) tick();

    // Error counter saturation.
    applyStimulus(1'b1, make_flit(NOPE, 6'd0, 16'h0000, 1'b0), 1'b1, 1'b0);
    repeat (260) tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("sat_err_count_1", 32'(err_count_1), 32'(255));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
